// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
//
// Round-robin write arbiter that merges NUM_REQ requester write ports into one
// shared FIFO write port. It moves a programmed number of words per run and
// hands the FIFO to one requester at a time in bursts of at most burst_len
// words. Run control uses the ap_ctrl handshake (ap_start/ap_idle/ap_ready/
// ap_done).
//
// Handshake semantics (both sides):
//   A word moves from requester k on a cycle where req_wr_en[k] && !req_full[k].
//   That same cycle the arbiter asserts fifo_wr_en, which is only ever high
//   while fifo_full is low, so every fifo_wr_en pulse is one accepted word.
//
// Ports:
//   ap_clk        in   clock, rising edge
//   ap_rst        in   synchronous active-high reset
//   ap_start      in   start a run (looked at only while idle)
//   ap_idle       out  block is idle
//   ap_ready      out  start accepted this cycle (combinational)
//   ap_done       out  one-cycle completion pulse
//   total         in   words to move in the run, latched at start
//   burst_len     in   max words per grant, latched at start (0 acts as 1)
//   req_wr_en     in   per-requester write request
//   req_wr_data   in   requester k data at [k*WIDTH +: WIDTH]
//   req_full      out  per-requester backpressure
//   fifo_wr_en    out  shared FIFO write strobe
//   fifo_wr_data  out  shared FIFO write data
//   fifo_full     in   shared FIFO full
//   dbg_state     out  current FSM state (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------
module fifo_wr_arb #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 2
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic                       ap_start,
  output logic                       ap_idle,
  output logic                       ap_ready,
  output logic                       ap_done,
  input  logic [31:0]                total,
  input  logic [7:0]                 burst_len,
  input  logic [NUM_REQ-1:0]         req_wr_en,
  input  logic [NUM_REQ*WIDTH-1:0]   req_wr_data,
  output logic [NUM_REQ-1:0]         req_full,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_wr_data,
  input  logic                       fifo_full,
  output logic [1:0]                 dbg_state
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [31:0]   total_q;
  logic [7:0]    burst_lim;
  logic [31:0]   word_cnt;
  logic [7:0]    burst_cnt;
  logic          grant_valid;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_owner;

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          owner_req;
  logic          in_run;
  logic          accept;
  logic [31:0]   word_cnt_nxt;
  logic [7:0]    burst_cnt_nxt;

  assign dbg_state     = state;
  assign in_run        = (state == S_RUN);
  assign owner_req     = req_wr_en[owner];
  assign accept        = in_run && grant_valid && owner_req && !fifo_full;
  assign word_cnt_nxt  = word_cnt + 32'd1;
  assign burst_cnt_nxt = burst_cnt + 8'd1;

  // Round-robin pick: first requester at or after last_owner+1, wrapping.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_idx   = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_owner) + i) % NUM_REQ;
      if (!sel_found && req_wr_en[idx]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(idx);
      end
    end
  end

  // Outputs are forced to their idle values while reset is asserted so the
  // reset cycle itself is already quiet, not just the cycles after it.
  assign ap_idle      = (state == S_IDLE) || ap_rst;
  assign ap_ready     = (state == S_IDLE) && ap_start && !ap_rst;
  assign ap_done      = (state == S_DONE) && !ap_rst;
  assign fifo_wr_en   = accept && !ap_rst;
  assign fifo_wr_data = req_wr_data[int'(owner)*WIDTH +: WIDTH];

  always_comb begin
    req_full = '1;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_full[k] = ap_rst || fifo_full ||
                    !(in_run && grant_valid && (owner == IW'(k)));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= S_IDLE;
      total_q     <= '0;
      burst_lim   <= 8'd1;
      word_cnt    <= '0;
      burst_cnt   <= '0;
      grant_valid <= 1'b0;
      owner       <= '0;
      last_owner  <= IW'(NUM_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            total_q     <= total;
            burst_lim   <= (burst_len == 8'd0) ? 8'd1 : burst_len;
            word_cnt    <= '0;
            burst_cnt   <= '0;
            grant_valid <= 1'b0;
            // Last owner = top index, so the first search begins at 0.
            last_owner  <= IW'(NUM_REQ - 1);
            state       <= (total == 32'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (!grant_valid) begin
            // Selection cycle: never accepts a word.
            if (sel_found) begin
              grant_valid <= 1'b1;
              owner       <= sel_idx;
              burst_cnt   <= '0;
            end
          end else if (accept) begin
            word_cnt  <= word_cnt_nxt;
            burst_cnt <= burst_cnt_nxt;
            // Run completion wins over burst completion.
            if (word_cnt_nxt == total_q) begin
              state       <= S_DONE;
              grant_valid <= 1'b0;
            end else if (burst_cnt_nxt == burst_lim) begin
              grant_valid <= 1'b0;
              last_owner  <= owner;
              burst_cnt   <= '0;
            end
          end else if (!owner_req) begin
            // Owner went quiet: give up the grant, its burst restarts later.
            grant_valid <= 1'b0;
            last_owner  <= owner;
            burst_cnt   <= '0;
          end
          // Otherwise the FIFO is full while the owner requests: hold.
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arb
//
// Bench for fifo_wr_arb (WIDTH=8, NUM_REQ=2). Requester k presents the word
// {k[1:0], n[5:0]} where n counts how many of its words have been taken, so
// every FIFO word identifies its source and its position in that source's
// stream.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arb;

  localparam int W  = 8;
  localparam int NR = 2;
  localparam int VW = 4 + NR + W;

  // clock / reset
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  logic          ap_start = 1'b0;
  logic          ap_idle, ap_ready, ap_done;
  logic [31:0]   total = '0;
  logic [7:0]    burst_len = '0;
  logic [NR-1:0] req_wr_en = '0;
  logic [NR*W-1:0] req_wr_data = '0;
  logic [NR-1:0] req_full;
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_wr_data;
  logic          fifo_full = 1'b0;
  logic [1:0]    dbg_state;

  fifo_wr_arb #(.WIDTH(W), .NUM_REQ(NR)) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .ap_start     (ap_start),
    .ap_idle      (ap_idle),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .total        (total),
    .burst_len    (burst_len),
    .req_wr_en    (req_wr_en),
    .req_wr_data  (req_wr_data),
    .req_full     (req_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .dbg_state    (dbg_state)
  );

  // bookkeeping
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [5:0]    req_cnt [NR];
  logic [W-1:0]  obs_q[$];
  logic [W-1:0]  exp_q[$];
  int            last_wr_cyc;
  int            done_cyc;
  bit            done_seen;

  logic [VW-1:0] act_vec;
  logic [VW-1:0] exp_vec;
  int            acc_idx;

  // reference model: run-level bookkeeping of the arbiter's rules
  int m_state = 0;   // 0 idle, 1 running, 2 done
  bit m_gv    = 0;
  int m_owner = 0;
  int m_last  = NR - 1;
  int m_words = 0;
  int m_burst = 0;
  int m_total = 0;
  int m_blen  = 1;

  task automatic set_data();
    for (int k = 0; k < NR; k++) req_wr_data[k*W +: W] = {2'(k), req_cnt[k]};
  endtask

  task automatic clear_run();
    for (int k = 0; k < NR; k++) req_cnt[k] = '0;
    set_data();
    obs_q.delete();
    exp_q.delete();
    done_seen = 0;
  endtask

  // Expected outputs for the current cycle from the model state and inputs.
  task automatic model_expect();
    logic [NR-1:0] ef;
    logic          ewr;
    logic [W-1:0]  ed;
    bool_run: begin end
    if (ap_rst) begin
      exp_vec = {1'b1, 1'b0, 1'b0, 1'b0, {NR{1'b1}}, {W{1'b0}}};
      acc_idx = -1;
      return;
    end
    ewr = (m_state == 1) && m_gv && req_wr_en[m_owner] && !fifo_full;
    for (int k = 0; k < NR; k++)
      ef[k] = !((m_state == 1) && m_gv && (m_owner == k)) || fifo_full;
    ed = ewr ? {2'(m_owner), req_cnt[m_owner]} : '0;
    exp_vec = {(m_state == 0), (m_state == 0) && ap_start, (m_state == 2), ewr, ef, ed};
    acc_idx = ewr ? m_owner : -1;
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_advance();
    if (ap_rst) begin
      m_state = 0; m_gv = 0; m_last = NR - 1; m_words = 0; m_burst = 0;
      return;
    end
    case (m_state)
      0: if (ap_start) begin
        m_total = int'(total);
        m_blen  = (burst_len == 0) ? 1 : int'(burst_len);
        m_words = 0; m_burst = 0; m_gv = 0; m_last = NR - 1;
        m_state = (m_total == 0) ? 2 : 1;
      end
      1: begin
        if (!m_gv) begin
          for (int i = 1; i <= NR; i++) begin
            if (!m_gv && req_wr_en[(m_last + i) % NR]) begin
              m_gv = 1; m_owner = (m_last + i) % NR; m_burst = 0;
            end
          end
        end else if (req_wr_en[m_owner] && !fifo_full) begin
          m_words++; m_burst++;
          if (m_words == m_total) begin
            m_state = 2; m_gv = 0;
          end else if (m_burst == m_blen) begin
            m_gv = 0; m_last = m_owner; m_burst = 0;
          end
        end else if (!req_wr_en[m_owner]) begin
          m_gv = 0; m_last = m_owner; m_burst = 0;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  // One clock cycle: sample on the falling edge, then step past the rising edge.
  task automatic cycle();
    @(negedge ap_clk);
    model_expect();
    act_vec = {ap_idle, ap_ready, ap_done, fifo_wr_en, req_full,
               fifo_wr_en ? fifo_wr_data : {W{1'b0}}};
    if (fifo_wr_en) begin
      obs_q.push_back(fifo_wr_data);
      last_wr_cyc = cyc;
    end
    if (ap_done) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
    model_advance();
    @(posedge ap_clk);
    #1;
    if (acc_idx >= 0) req_cnt[acc_idx] = req_cnt[acc_idx] + 6'd1;
    set_data();
    cyc++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    ap_rst = 1'b1;
    ap_start = 1'b1;
    req_wr_en = '1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset cyc=%0d act=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    ap_rst = 1'b0;
    ap_start = 1'b0;
    req_wr_en = '0;
    for (int c = 0; c < 2; c++) begin
      cycle();
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d act=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_basic();
    clear_run();
    req_wr_en = 2'b11; fifo_full = 1'b0; total = 8; burst_len = 2; ap_start = 1'b1;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      cycle();
      ap_start = 1'b0;
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL basic cyc=%0d act=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    n_cmp++;
    if (!done_seen) begin n_fail++; $display("FAIL basic_timeout act=no_done exp=done"); end
    exp_q = {8'h00, 8'h01, 8'h40, 8'h41, 8'h02, 8'h03, 8'h42, 8'h43};
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_fail++; $display("FAIL basic_count act=%0d exp=8", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_word[%0d] act=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (done_seen && (done_cyc - last_wr_cyc) != 1) begin
      n_fail++; $display("FAIL basic_done_lat act=%0d exp=1", done_cyc - last_wr_cyc);
    end
    req_wr_en = '0;
  endtask

  task automatic test_zero_total();
    int start_cyc;
    clear_run();
    req_wr_en = 2'b11; total = 0; burst_len = 3; ap_start = 1'b1;
    start_cyc = cyc;
    for (int c = 0; c < 10 && !done_seen; c++) begin
      cycle();
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL zero cyc=%0d act=%h exp=%h", cyc, act_vec, exp_vec);
      end
      if (c == 0) begin
        n_cmp++;
        if (act_vec[VW-2] !== 1'b1) begin
          n_fail++; $display("FAIL zero_ready act=%b exp=1", act_vec[VW-2]);
        end
      end
      ap_start = 1'b0;
    end
    n_cmp++;
    if (!done_seen || (done_cyc - start_cyc) != 1) begin
      n_fail++; $display("FAIL zero_done act=%0d exp=1", done_seen ? done_cyc - start_cyc : -1);
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL zero_words act=%0d exp=0", obs_q.size());
    end
    req_wr_en = '0;
  endtask

  task automatic test_single();
    clear_run();
    req_wr_en = 2'b10; total = 5; burst_len = 0; ap_start = 1'b1;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      cycle();
      ap_start = 1'b0;
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL single cyc=%0d act=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    n_cmp++;
    if (!done_seen) begin n_fail++; $display("FAIL single_timeout act=no_done exp=done"); end
    exp_q = {8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    n_cmp++;
    if (obs_q.size() != 5) begin
      n_fail++; $display("FAIL single_count act=%0d exp=5", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL single_word[%0d] act=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    req_wr_en = '0;
  endtask

  task automatic test_fifo_full();
    clear_run();
    req_wr_en = 2'b11; total = 8; burst_len = 4; ap_start = 1'b1;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      cycle();
      ap_start = 1'b0;
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL full cyc=%0d act=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    fifo_full = 1'b0;
    n_cmp++;
    if (!done_seen) begin n_fail++; $display("FAIL full_timeout act=no_done exp=done"); end
    exp_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h40, 8'h41, 8'h42, 8'h43};
    n_cmp++;
    if (obs_q.size() != 8) begin
      n_fail++; $display("FAIL full_count act=%0d exp=8", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL full_word[%0d] act=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    req_wr_en = '0;
  endtask

  task automatic test_drop();
    clear_run();
    total = 6; burst_len = 4; ap_start = 1'b1;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      req_wr_en = {1'b1, !(c >= 3 && c <= 5)};
      cycle();
      ap_start = 1'b0;
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL drop cyc=%0d act=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    n_cmp++;
    if (!done_seen) begin n_fail++; $display("FAIL drop_timeout act=no_done exp=done"); end
    exp_q = {8'h00, 8'h40, 8'h41, 8'h42, 8'h43, 8'h01};
    n_cmp++;
    if (obs_q.size() != 6) begin
      n_fail++; $display("FAIL drop_count act=%0d exp=6", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL drop_word[%0d] act=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    req_wr_en = '0;
  endtask

  task automatic test_reset_mid();
    clear_run();
    req_wr_en = 2'b11; total = 10; burst_len = 2; ap_start = 1'b1;
    for (int c = 0; c < 40 && obs_q.size() < 3; c++) begin
      cycle();
      ap_start = 1'b0;
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_run cyc=%0d act=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    ap_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) ap_rst = 1'b0;
      cycle();
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_after cyc=%0d act=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    n_cmp++;
    if (done_seen || obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL rstmid_abort act=done%0d/words%0d exp=done0/words3", done_seen, obs_q.size());
    end
    // Requester streams continue; a fresh run searches from 0 again.
    obs_q.delete();
    done_seen = 0;
    total = 4; burst_len = 2; ap_start = 1'b1;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      cycle();
      ap_start = 1'b0;
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rstmid_rerun cyc=%0d act=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    exp_q = {8'h02, 8'h03, 8'h41, 8'h42};
    n_cmp++;
    if (!done_seen || obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL rstmid_rerun_count act=done%0d/words%0d exp=done1/words4", done_seen, obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_word[%0d] act=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    req_wr_en = '0;
  endtask

  task automatic test_random();
    int t;
    for (int r = 0; r < 8; r++) begin
      clear_run();
      t = $urandom_range(0, 12);
      total = 32'(t);
      burst_len = 8'($urandom_range(0, 4));
      ap_start = 1'b1;
      for (int c = 0; c < 400 && !done_seen; c++) begin
        req_wr_en = NR'($urandom_range(0, 3));
        fifo_full = ($urandom_range(0, 3) == 0);
        cycle();
        ap_start = 1'b0;
        n_cmp++;
        if (act_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL random%0d cyc=%0d act=%h exp=%h", r, cyc, act_vec, exp_vec);
        end
      end
      fifo_full = 1'b0;
      req_wr_en = '0;
      n_cmp++;
      if (!done_seen || obs_q.size() != t) begin
        n_fail++;
        $display("FAIL random%0d_words act=done%0d/words%0d exp=done1/words%0d",
                 r, done_seen, obs_q.size(), t);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    for (int k = 0; k < NR; k++) req_cnt[k] = '0;
    set_data();
    test_reset();
    test_basic();
    test_zero_total();
    test_single();
    test_fifo_full();
    test_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameters: WIDTH, default 8, data word width; NUM_REQ, default 2, number of requesters (legal range 2..4).
REQ-002 ap_clk  in  1  the only clock; all logic SHALL be on its rising edge.
REQ-003 ap_rst  in  1  reset, synchronous and active-high.
REQ-004 req_wr_en  in  NUM_REQ  per-requester write request.
REQ-005 req_wr_data  in  NUM_REQ*WIDTH  requester k data at bits [k*WIDTH +: WIDTH].
REQ-006 req_full  out  NUM_REQ  per-requester backpressure; the requester SHALL treat a write as accepted only when req_wr_en[k] && !req_full[k].
REQ-007 fifo_wr_en  out  1; fifo_wr_data  out  WIDTH; fifo_full  in  1: the shared FIFO write port.
REQ-008 total  in  32  words to transfer per run; burst_len  in  8  maximum words per grant; both sampled at start.
REQ-009 ap_start  in  1; ap_idle, ap_ready, ap_done  out  1: the block-level ap_ctrl handshake.

Function
REQ-010 FSM states: IDLE, RUN, DONE.
REQ-011 In IDLE: ap_idle=1; when ap_start=1, ap_ready=1 combinationally in the same cycle, total and burst_len are latched, and the word counter clears.
REQ-012 On the IDLE exit, the FSM SHALL go to RUN, or directly to DONE if total=0.
REQ-013 Latched burst_len=0 SHALL be treated as 1.
REQ-014 In RUN and DONE, ap_idle=0; ap_start is ignored outside IDLE.
REQ-015 Arbitration in RUN with no grant held: select the first index with req_wr_en=1, searching from (last_owner+1) mod NUM_REQ upward with wrap.
REQ-016 The first selection after reset or start searches from index 0.
REQ-017 The grant register (owner index, valid flag) SHALL be updated on the next edge after selection; selection and acceptance never occur in the same cycle.
REQ-018 fifo_wr_en = state==RUN && grant_valid && req_wr_en[owner] && !fifo_full.
REQ-019 fifo_wr_data = owner's req_wr_data slice.
REQ-020 req_full[k] = !(state==RUN && grant_valid && owner==k) || fifo_full.
REQ-021 Each accepted word SHALL increment the 32-bit word counter and the burst counter.
REQ-022 Grant release: grant_valid SHALL clear on the edge after the accepted word that makes the burst count equal burst_len; last_owner is recorded and the burst counter clears.
REQ-023 Grant release also occurs on the edge after any cycle where the owner has req_wr_en=0.
REQ-024 If fifo_full=1 while the owner requests, the grant SHALL be held with no release, no counting and no acceptance.
REQ-025 The accepted word that makes the word count equal total SHALL move the FSM to DONE on the next edge and clear grant_valid; no further words are accepted.
REQ-026 DONE lasts exactly one cycle with ap_done=1 (registered, state==DONE), then returns to IDLE.
REQ-027 Simultaneous burst completion and total completion: DONE takes priority, and no new selection is made.
REQ-028 A requester that stops requesting mid-burst loses the grant; when re-granted, its burst count restarts from 0.

Reset
REQ-029 ap_rst=1 at any edge, including mid-RUN: state=IDLE, grant_valid=0, last_owner=NUM_REQ-1 (so the first search starts at 0), counters=0.
REQ-030 During and after reset: ap_ready=0, ap_done=0, ap_idle=1, fifo_wr_en=0, req_full all 1.
REQ-031 A run interrupted by reset SHALL NOT assert ap_done.

Verification
REQ-032 NUM_REQ=2, total=8, burst_len=2, both requesters always requesting, fifo_full=0 -> owner sequence 0,0,1,1,0,0,1,1 with one idle arbitration cycle between bursts; ap_done one cycle after the 8th word.
REQ-033 total=0 with ap_start -> ap_ready in the start cycle, ap_done the next cycle, zero fifo_wr_en pulses.
REQ-034 Only requester 1 requesting, total=5, burst_len=0 -> five words from requester 1, each burst of length 1, ap_done after the 5th word.
REQ-035 fifo_full held high for 3 cycles mid-burst -> fifo_wr_en=0 and req_full=1 for those cycles; owner and counters unchanged; transfer resumes with the same owner.
REQ-036 Owner drops req_wr_en after 1 of 4 burst words -> grant passes to the other requester; both word counts stay exact.
REQ-037 ap_rst pulsed after 3 of 10 words -> ap_idle=1, no ap_done; a new ap_start with total=4 completes with exactly 4 words.
